vec_stream_scheduler: RTL
=========================

VEC_STREAM_SCHEDULER -- requirements
Module: vec_stream_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of vector requesters (>=1).
REQ-002 SHALL have parameter VEC_BYTES, default 4, meaning the bytes per requester vector.
REQ-003 SHALL have parameter AXIS_BYTES, default 1, meaning the stream width in bytes; VEC_BYTES % AXIS_BYTES == 0 is statically asserted.
REQ-004 SHALL have parameter MSB_FIRST, default 0, meaning: 0 = least-significant beat first, 1 = most-significant beat first.
REQ-005 SHALL have clk  input  1  clock; all logic is on the rising edge.
REQ-006 SHALL have sresetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have req_valid  input  NUM_SRC  per-source request to send its vector.
REQ-008 SHALL have req_vec  input  NUM_SRC*VEC_BYTES*8  concatenated vectors; source i occupies slice i.
REQ-009 SHALL have req_ready  output  NUM_SRC  one-hot acceptance; a vector transfers when req_valid[i] & req_ready[i].
REQ-010 SHALL have axis_tdata  output  AXIS_BYTES*8  stream beat data.
REQ-011 SHALL have axis_tvalid  output  1, axis_tready  input  1, axis_tlast  output  1, and axis_tkeep  output  AXIS_BYTES.
REQ-012 SHALL have axis_tdest  output  DEST_W  the index of the source owning the packet; DEST_W = max(1, clog2(NUM_SRC)).
REQ-013 SHALL have busy  output  1  high while a packet is in flight.

Function
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 In IDLE with any req_valid high, SHALL select winner g by round-robin: the first asserted index searching from (last_grant+1) mod NUM_SRC upward with wrap.
REQ-016 SHALL drive req_ready[g]=1 combinationally in that same IDLE cycle, and no other req_ready bit; all req_ready bits SHALL be 0 in SEND.
REQ-017 On acceptance, SHALL register req_vec slice g into a capture register, set last_grant=g and tdest=g, load the beat counter, and go to SEND.
REQ-018 After acceptance, the source's vector may change without affecting the packet in flight.
REQ-019 In SEND, SHALL hold axis_tvalid=1, which is a registered state decode; in IDLE, SHALL hold axis_tvalid=0.
REQ-020 SHALL emit BEATS = VEC_BYTES/AXIS_BYTES beats per packet.
REQ-021 Beat k (k=0..BEATS-1) SHALL carry capture[(idx+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8], with idx=k for MSB_FIRST=0 and idx=BEATS-1-k for MSB_FIRST=1.
REQ-022 The beat counter SHALL advance only on axis_tvalid & axis_tready; tdata, tdest and tlast SHALL remain stable while stalled.
REQ-023 SHALL assert axis_tlast only on beat BEATS-1; when BEATS==1, every beat is last.
REQ-024 The counter width SHALL be max(1, clog2(BEATS)).
REQ-025 SHALL hold axis_tkeep all-ones.
REQ-026 On the last-beat handshake, SHALL return to IDLE; one idle bubble cycle between packets is required and sufficient.
REQ-027 Arbitration SHALL be packet-atomic: grant never changes mid-packet, regardless of req_valid changes.
REQ-028 Every continuously requesting source SHALL be served within NUM_SRC packets.
REQ-029 busy SHALL equal (state==SEND).

Reset
REQ-030 While sresetn=0 at a clock edge, SHALL set state=IDLE, axis_tvalid=0, busy=0, req_ready=0, counter=0, tdest=0, and last_grant=NUM_SRC-1, so source 0 has first priority.
REQ-031 Reset mid-packet SHALL abandon the packet: no further beats and no tlast; the next packet starts from a fresh arbitration.
REQ-032 The capture register need not be reset.

Structure
REQ-033 Package vec_sched_pkg SHALL hold the state enum and the width functions (DEST_W, counter width).
REQ-034 The round-robin selection SHALL be a separate sub-module rr_arbiter (inputs: request vector, last_grant; outputs: grant index, any_req).

Verification
REQ-035 NUM_SRC=4, VEC_BYTES=4, AXIS_BYTES=1, MSB_FIRST=0; after reset, req_valid=0001, vec0=0x44332211, tready=1 -> beats 11,22,33,44; tlast on 44; tdest=0; req_ready[0] pulses 1 cycle.
REQ-036 Same config, all four req_valid held high -> packet tdest order 0,1,2,3,0; one idle cycle between packets.
REQ-037 MSB_FIRST=1, vec2=0xA1B2C3D4 only -> beats A1,B2,C3,D4; tdest=2.
REQ-038 tready toggled 1,0,0,1,... during a packet -> no beat skipped or duplicated, data stable during stalls; req_valid[1] rising mid-packet does not alter the current tdest.
REQ-039 sresetn pulsed low after beat 2 of a source-3 packet -> tvalid=0 the next cycle and no tlast; with req_valid=1000, the next packet is a full 4 beats from source 3.
REQ-040 AXIS_BYTES=VEC_BYTES=2, vec1=0xBEEF -> single beat 0xBEEF with tlast=1 and tdest=1.

Source files
------------

// File: rtl/vec_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_sched_pkg                                                |
// | Description : Shared types and width helpers for the vector stream         |
// |               scheduler (FSM state encoding, tdest / beat counter widths). |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vec_sched_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Width of a source index; a single source still needs one bit.
   function automatic int dest_width(input int num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

   // Width of the beat counter; a one-beat packet still needs one bit.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_stream_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin pick. Returns the first asserted   |
// |               request searching upward from last_grant+1 with wrap.        |
// | Ports       : req        - request vector                                  |
// |               last_grant - index granted most recently                     |
// |               grant_idx  - winning index (valid when any_req)              |
// |               any_req    - at least one request asserted                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter
   import vec_sched_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = dest_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   logic [IDX_W-1:0] w_cand;

   // Walk offsets 1..NUM_SRC so last_grant itself is examined last.
   always_comb begin
      grant_idx = '0;
      any_req   = 1'b0;
      w_cand    = '0;
      for (int off = 1; off <= NUM_SRC; off++) begin
         w_cand = IDX_W'((int'(last_grant) + off) % NUM_SRC);
         if (!any_req && req[w_cand]) begin
            any_req   = 1'b1;
            grant_idx = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vec_stream_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_stream_scheduler                                         |
// | Description : Round-robin scheduler that accepts one whole vector from one |
// |               of NUM_SRC requesters and serialises it onto an AXI-Stream   |
// |               as VEC_BYTES/AXIS_BYTES beats, tagged with the source index. |
// | Ports       : clk, sresetn (sync, active-low)                              |
// |               req_valid/req_vec/req_ready - per-source vector handshake    |
// |               axis_t*                     - AXI-Stream master             |
// |               busy                        - packet in flight               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vec_stream_scheduler
   import vec_sched_pkg::*;
#(
   parameter  int NUM_SRC    = 4,
   parameter  int VEC_BYTES  = 4,
   parameter  int AXIS_BYTES = 1,
   parameter  int MSB_FIRST  = 0,
   localparam int DEST_W     = dest_width(NUM_SRC)
) (
   input  logic                           clk,
   input  logic                           sresetn,
   input  logic [NUM_SRC-1:0]             req_valid,
   input  logic [NUM_SRC*VEC_BYTES*8-1:0] req_vec,
   output logic [NUM_SRC-1:0]             req_ready,
   output logic [AXIS_BYTES*8-1:0]        axis_tdata,
   output logic                           axis_tvalid,
   input  logic                           axis_tready,
   output logic                           axis_tlast,
   output logic [AXIS_BYTES-1:0]          axis_tkeep,
   output logic [DEST_W-1:0]              axis_tdest,
   output logic                           busy
);

   localparam int c_VEC_W  = VEC_BYTES * 8;
   localparam int c_BEAT_W = AXIS_BYTES * 8;
   localparam int c_BEATS  = VEC_BYTES / AXIS_BYTES;
   localparam int c_CNT_W  = cnt_width(c_BEATS);
   localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_BEATS - 1);

   generate
      if ((VEC_BYTES % AXIS_BYTES) != 0) begin : g_bad_width
         $error("vec_stream_scheduler: VEC_BYTES must be a multiple of AXIS_BYTES");
      end
   endgenerate

   state_t             r_state;
   state_t             w_state_next;
   logic [c_VEC_W-1:0] r_capture;
   logic [c_CNT_W-1:0] r_cnt;
   logic [DEST_W-1:0]  r_dest;
   logic [DEST_W-1:0]  r_last_grant;
   logic [DEST_W-1:0]  w_grant;
   logic               w_any_req;
   logic               w_accept;
   logic               w_beat_xfer;
   logic               w_last_beat;
   logic [c_CNT_W-1:0] w_beat_idx;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (DEST_W)
   ) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (r_last_grant),
      .grant_idx  (w_grant),
      .any_req    (w_any_req)
   );

   assign w_last_beat = (r_cnt == c_LAST_CNT);
   assign w_beat_xfer = axis_tvalid & axis_tready;

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Grant is only offered in IDLE, so a packet can never be re-arbitrated
   // mid-flight. Gating with sresetn keeps req_ready low throughout reset.
   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (sresetn && w_any_req) begin
               req_ready[w_grant] = 1'b1;
               w_accept           = 1'b1;
               w_state_next       = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_beat_xfer && w_last_beat) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         r_cnt        <= '0;
         r_dest       <= '0;
         r_last_grant <= DEST_W'(NUM_SRC - 1);
      end else if (w_accept) begin
         r_cnt        <= '0;
         r_dest       <= w_grant;
         r_last_grant <= w_grant;
      end else if (w_beat_xfer) begin
         r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
      end
   end

   // Snapshot of the winner's vector; the source is free to change it after.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_capture <= req_vec[w_grant*c_VEC_W +: c_VEC_W];
      end
   end

   assign w_beat_idx  = (MSB_FIRST != 0) ? (c_LAST_CNT - r_cnt) : r_cnt;
   assign axis_tdata  = r_capture[w_beat_idx*c_BEAT_W +: c_BEAT_W];
   assign axis_tvalid = (r_state == ST_SEND);
   assign axis_tlast  = axis_tvalid & w_last_beat;
   assign axis_tkeep  = '1;
   assign axis_tdest  = r_dest;
   assign busy        = (r_state == ST_SEND);

endmodule
`default_nettype wire
